// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INST_BYTES = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        HOLD = 2'b11
    } fetch_state_t;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/grant/response bus between fetch and memory.
interface fetch_ctrl_if import fetch_ctrl_pkg::*; ();

    logic            im_req;
    logic [XLEN-1:0] im_addr;
    logic            im_gnt;
    logic            im_rvalid;
    logic [XLEN-1:0] im_rdata;

    modport master (
        output im_req, im_addr,
        input  im_gnt, im_rvalid, im_rdata
    );

    modport slave (
        input  im_req, im_addr,
        output im_gnt, im_rvalid, im_rdata
    );

endinterface

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch FSM with holding buffer and
// wrong-path drop on branch redirect.
module fetch_ctrl import fetch_ctrl_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PC_Write,
    input  logic            Stall,
    input  logic            Branch_Taken,
    input  logic [XLEN-1:0] Branch_Target,
    fetch_ctrl_if.master    im,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] PCAdd4_out,
    output logic            IM_busy
);

    fetch_state_t    state_r, state_n_s;
    logic [XLEN-1:0] pc_r, pc_n_s;
    logic [XLEN-1:0] buf_r, buf_n_s;
    logic            drop_r, drop_n_s;

    logic            word_valid_s;
    logic            present_s;
    logic            deliver_s;
    logic [XLEN-1:0] pc_inc_s;

    assign pc_inc_s = pc_plus4(pc_r);

    // A word is available from memory this cycle, or from the holding buffer.
    always_comb begin
        word_valid_s = 1'b0;
        if (state_r == WAIT) begin
            word_valid_s = im.im_rvalid & ~drop_r;
        end else if (state_r == HOLD) begin
            word_valid_s = 1'b1;
        end else begin
            word_valid_s = 1'b0;
        end
    end

    // A redirect squashes whatever word is on offer this cycle.
    assign present_s = word_valid_s & ~Branch_Taken;
    assign deliver_s = present_s & PC_Write & ~Stall;

    // IF/ID presentation and memory request decode.
    always_comb begin
        inst_out   = 32'd0;
        PCAdd4_out = 32'd0;
        if (present_s) begin
            inst_out   = (state_r == HOLD) ? buf_r : im.im_rdata;
            PCAdd4_out = pc_inc_s;
        end else begin
            inst_out   = 32'd0;
            PCAdd4_out = 32'd0;
        end
    end

    assign IM_busy    = ~present_s;
    assign im.im_req  = (state_r == REQ);
    assign im.im_addr = (state_r == REQ) ? pc_r : 32'd0;

    // Next-state, PC, buffer and drop-flag computation.
    always_comb begin
        state_n_s = state_r;
        pc_n_s    = pc_r;
        buf_n_s   = buf_r;
        drop_n_s  = drop_r;
        case (state_r)
            IDLE: begin
                state_n_s = REQ;
            end
            REQ: begin
                if (Branch_Taken) begin
                    pc_n_s = Branch_Target;
                end else begin
                    pc_n_s = pc_r;
                end
                if (im.im_gnt) begin
                    state_n_s = WAIT;
                    drop_n_s  = Branch_Taken;
                end else begin
                    state_n_s = REQ;
                end
            end
            WAIT: begin
                if (im.im_rvalid) begin
                    drop_n_s = 1'b0;
                    if (Branch_Taken) begin
                        pc_n_s    = Branch_Target;
                        state_n_s = REQ;
                    end else if (drop_r) begin
                        state_n_s = REQ;
                    end else if (deliver_s) begin
                        pc_n_s    = pc_inc_s;
                        state_n_s = REQ;
                    end else begin
                        buf_n_s   = im.im_rdata;
                        state_n_s = HOLD;
                    end
                end else if (Branch_Taken) begin
                    pc_n_s   = Branch_Target;
                    drop_n_s = 1'b1;
                end else begin
                    state_n_s = WAIT;
                end
            end
            HOLD: begin
                if (Branch_Taken) begin
                    pc_n_s    = Branch_Target;
                    state_n_s = REQ;
                end else if (deliver_s) begin
                    pc_n_s    = pc_inc_s;
                    state_n_s = REQ;
                end else begin
                    state_n_s = HOLD;
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any in-flight request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            pc_r    <= RESET_PC;
            buf_r   <= 32'd0;
            drop_r  <= 1'b0;
        end else begin
            state_r <= state_n_s;
            pc_r    <= pc_n_s;
            buf_r   <= buf_n_s;
            drop_r  <= drop_n_s;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: handshake, stall hold, branch drop,
// PC wrap and reset abandonment.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst0, rst1;
    logic        pcw0, stall0, br0, pcw1, stall1, br1;
    logic [31:0] tgt0, tgt1;
    logic [31:0] inst0, pca0, inst1, pca1;
    logic        busy0, busy1;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    fetch_ctrl_if bus0 ();
    fetch_ctrl_if bus1 ();

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst0), .PC_Write(pcw0), .Stall(stall0),
        .Branch_Taken(br0), .Branch_Target(tgt0), .im(bus0.master),
        .inst_out(inst0), .PCAdd4_out(pca0), .IM_busy(busy0)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst(rst1), .PC_Write(pcw1), .Stall(stall1),
        .Branch_Taken(br1), .Branch_Target(tgt1), .im(bus1.master),
        .inst_out(inst1), .PCAdd4_out(pca1), .IM_busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst0 = 1'b0; rst1 = 1'b0;
        pcw0 = 1'b1; stall0 = 1'b0; br0 = 1'b0; tgt0 = 32'd0;
        pcw1 = 1'b1; stall1 = 1'b0; br1 = 1'b0; tgt1 = 32'd0;
        bus0.im_gnt = 1'b0; bus0.im_rvalid = 1'b0; bus0.im_rdata = 32'd0;
        bus1.im_gnt = 1'b0; bus1.im_rvalid = 1'b0; bus1.im_rdata = 32'd0;
        step(); step();
        #1;
        check_eq("rst_req",   {31'd0, bus0.im_req}, 32'd0);
        check_eq("rst_addr",  bus0.im_addr, 32'd0);
        check_eq("rst_inst",  inst0, 32'd0);
        check_eq("rst_pca",   pca0, 32'd0);
        check_eq("rst_busy",  {31'd0, busy0}, 32'd1);

        // Basic fetch: IDLE one cycle, then request at RESET_PC.
        step(); rst0 = 1'b1; #1;
        check_eq("idle_req", {31'd0, bus0.im_req}, 32'd0);
        step();
        check_eq("req0_req",  {31'd0, bus0.im_req}, 32'd1);
        check_eq("req0_addr", bus0.im_addr, 32'd0);
        bus0.im_gnt = 1'b1;
        step();
        bus0.im_gnt = 1'b0;
        bus0.im_rvalid = 1'b1; bus0.im_rdata = 32'h0000_0013; #1;
        check_eq("wait_req",  {31'd0, bus0.im_req}, 32'd0);
        check_eq("d0_inst",   inst0, 32'h0000_0013);
        check_eq("d0_pca",    pca0, 32'd4);
        check_eq("d0_busy",   {31'd0, busy0}, 32'd0);
        step();
        bus0.im_rvalid = 1'b0; #1;
        check_eq("req1_addr", bus0.im_addr, 32'd4);
        check_eq("req1_busy", {31'd0, busy0}, 32'd1);
        check_eq("req1_inst", inst0, 32'd0);

        // Stall for three cycles: hold buffer, no request.
        bus0.im_gnt = 1'b1;
        step();
        bus0.im_gnt = 1'b0;
        bus0.im_rvalid = 1'b1; bus0.im_rdata = 32'hABCD_0123; stall0 = 1'b1; #1;
        check_eq("st1_inst", inst0, 32'hABCD_0123);
        step();
        bus0.im_rvalid = 1'b0; bus0.im_rdata = 32'h5555_5555; #1;
        check_eq("st2_inst", inst0, 32'hABCD_0123);
        check_eq("st2_req",  {31'd0, bus0.im_req}, 32'd0);
        check_eq("st2_pca",  pca0, 32'd8);
        step();
        check_eq("st3_inst", inst0, 32'hABCD_0123);
        check_eq("st3_req",  {31'd0, bus0.im_req}, 32'd0);
        stall0 = 1'b0; #1;
        check_eq("st_dlv_busy", {31'd0, busy0}, 32'd0);
        step();
        check_eq("st_next_addr", bus0.im_addr, 32'd8);

        // Branch in WAIT before rvalid: returned word discarded.
        bus0.im_gnt = 1'b1;
        step();
        bus0.im_gnt = 1'b0; br0 = 1'b1; tgt0 = 32'h0000_0100; #1;
        check_eq("bw_busy0", {31'd0, busy0}, 32'd1);
        step();
        br0 = 1'b0; bus0.im_rvalid = 1'b1; bus0.im_rdata = 32'hDEAD_BEEF; #1;
        check_eq("bw_req",   {31'd0, bus0.im_req}, 32'd0);
        check_eq("bw_busy1", {31'd0, busy0}, 32'd1);
        check_eq("bw_inst",  inst0, 32'd0);
        step();
        bus0.im_rvalid = 1'b0; #1;
        check_eq("bw_addr", bus0.im_addr, 32'h0000_0100);
        check_eq("bw_reqn", {31'd0, bus0.im_req}, 32'd1);

        // PC_Write=0 forces HOLD; branch in HOLD drops the held word.
        bus0.im_gnt = 1'b1;
        step();
        bus0.im_gnt = 1'b0; pcw0 = 1'b0;
        bus0.im_rvalid = 1'b1; bus0.im_rdata = 32'h1111_2222;
        step();
        bus0.im_rvalid = 1'b0; #1;
        check_eq("bh_inst", inst0, 32'h1111_2222);
        check_eq("bh_pca",  pca0, 32'h0000_0104);
        br0 = 1'b1; tgt0 = 32'h0000_0200; pcw0 = 1'b1; #1;
        check_eq("bh_busy",  {31'd0, busy0}, 32'd1);
        check_eq("bh_inst0", inst0, 32'd0);
        step();
        br0 = 1'b0; #1;
        check_eq("bh_addr", bus0.im_addr, 32'h0000_0200);

        // Branch in REQ without grant retargets; with grant sets drop.
        br0 = 1'b1; tgt0 = 32'h0000_0300;
        step();
        br0 = 1'b0; #1;
        check_eq("br_nogr_addr", bus0.im_addr, 32'h0000_0300);
        br0 = 1'b1; tgt0 = 32'h0000_0400; bus0.im_gnt = 1'b1;
        step();
        br0 = 1'b0; bus0.im_gnt = 1'b0;
        bus0.im_rvalid = 1'b1; bus0.im_rdata = 32'h7777_7777; #1;
        check_eq("br_gr_busy", {31'd0, busy0}, 32'd1);
        step();
        bus0.im_rvalid = 1'b0; #1;
        check_eq("br_gr_addr", bus0.im_addr, 32'h0000_0400);

        // Reset in WAIT; late rvalid in IDLE ignored.
        bus0.im_gnt = 1'b1;
        step();
        bus0.im_gnt = 1'b0; rst0 = 1'b0; #1;
        check_eq("rw_req",  {31'd0, bus0.im_req}, 32'd0);
        check_eq("rw_busy", {31'd0, busy0}, 32'd1);
        step();
        rst0 = 1'b1; bus0.im_rvalid = 1'b1; bus0.im_rdata = 32'h9999_9999; #1;
        check_eq("rw_late_busy", {31'd0, busy0}, 32'd1);
        check_eq("rw_late_inst", inst0, 32'd0);
        step();
        bus0.im_rvalid = 1'b0; #1;
        check_eq("rw_restart_req",  {31'd0, bus0.im_req}, 32'd1);
        check_eq("rw_restart_addr", bus0.im_addr, 32'd0);

        // RESET_PC at top of address space: PC+4 wraps.
        rst1 = 1'b1;
        step();
        step();
        check_eq("wr_addr0", bus1.im_addr, 32'hFFFF_FFFC);
        bus1.im_gnt = 1'b1;
        step();
        bus1.im_gnt = 1'b0; bus1.im_rvalid = 1'b1; bus1.im_rdata = 32'h0000_0013; #1;
        check_eq("wr_inst", inst1, 32'h0000_0013);
        check_eq("wr_pca",  pca1, 32'd0);
        step();
        bus1.im_rvalid = 1'b0; #1;
        check_eq("wr_addr1", bus1.im_addr, 32'd0);
        check_eq("wr_req1",  {31'd0, bus1.im_req}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
